// File: rtl/dds_wave_core.sv
// dds_wave_core: per-channel DDS playback of one of 2**WAVE_STORE loadable single-period tables.
// Latency: acc -> addr_r -> wave_out is 2 cycles; no backpressure, one table word taken per wr_valid.
`timescale 1ns/1ps
module dds_wave_core #(
  parameter int HORIZON_RESOLUTION  = 12,
  parameter int ADDER_LOWBIT        = 20,
  parameter int WAVE_STORE          = 2,
  parameter int VERTICAL_RESOLUTION = 8
) (
  input  logic                                                         clk,
  input  logic                                                         rstn,
  input  logic [WAVE_STORE-1:0]                                        wave_sel,
  input  logic [(2**WAVE_STORE)*(HORIZON_RESOLUTION+ADDER_LOWBIT)-1:0] freq_ctrl,
  input  logic [(2**WAVE_STORE)*HORIZON_RESOLUTION-1:0]                phase_ctrl,
  output logic [VERTICAL_RESOLUTION-1:0]                               wave_out,
  input  logic                                                         wr_enable,
  input  logic                                                         wr_valid,
  input  logic [31:0]                                                  wr_data
);

  localparam int HR        = HORIZON_RESOLUTION;
  localparam int AW        = HORIZON_RESOLUTION + ADDER_LOWBIT;
  localparam int NS        = 2**WAVE_STORE;
  localparam int VR        = VERTICAL_RESOLUTION;
  localparam int LANES     = 32 / VR;
  localparam int LANE_BITS = 2;
  localparam int ROW_W     = WAVE_STORE + HR - LANE_BITS;
  localparam int ROWS      = 2**ROW_W;
  localparam logic [HR-1:0] PTR_STEP = HR'(LANES);

  logic [AW-1:0] freq_arr  [NS];
  logic [HR-1:0] phase_arr [NS];

  for (genvar k = 0; k < NS; k++) begin : g_unpack
    assign freq_arr[k]  = freq_ctrl[k*AW +: AW];
    assign phase_arr[k] = phase_ctrl[k*HR +: HR];
  end

  logic [WAVE_STORE-1:0] sel_r;
  logic [WAVE_STORE-1:0] rd_store;
  logic [AW-1:0]         acc;
  logic [HR-1:0]         addr_r;
  logic [WAVE_STORE-1:0] wr_store;
  logic [HR-1:0]         wr_ptr;
  logic                  wr_enable_d;
  logic                  first_cyc;

  // Table is split into byte lanes so a 32-bit word lands in one row of each lane.
  logic [VR-1:0] tbl [LANES][ROWS];

  logic                  wr_rise;
  logic                  wr_fire;
  logic [WAVE_STORE-1:0] wr_store_eff;
  logic [HR-1:0]         wr_ptr_eff;
  logic [ROW_W-1:0]      wr_row;
  logic [ROW_W-1:0]      rd_row;
  logic [VR-1:0]         rd_sample;
  logic                  acc_clr;
  logic [AW-1:0]         acc_nxt;
  logic [HR-1:0]         addr_nxt;

  // A word arriving on the same cycle as the load start still goes to sample 0 of the new store.
  assign wr_rise      = wr_enable & ~wr_enable_d;
  assign wr_fire      = wr_enable & wr_valid;
  assign wr_store_eff = wr_rise ? wave_sel : wr_store;
  assign wr_ptr_eff   = wr_rise ? '0 : wr_ptr;
  assign wr_row       = {wr_store_eff, wr_ptr_eff[HR-1:LANE_BITS]};

  assign rd_row    = {rd_store, addr_r[HR-1:LANE_BITS]};
  assign rd_sample = tbl[addr_r[LANE_BITS-1:0]][rd_row];

  assign acc_clr  = wr_enable | (sel_r != wave_sel) | first_cyc;
  assign acc_nxt  = acc + freq_arr[sel_r];
  assign addr_nxt = acc[AW-1:ADDER_LOWBIT] + phase_arr[sel_r];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_enable_d <= 1'b0;
      wr_store    <= '0;
      wr_ptr      <= '0;
      first_cyc   <= 1'b1;
      sel_r       <= '0;
      rd_store    <= '0;
      acc         <= '0;
      addr_r      <= '0;
      wave_out    <= '0;
    end else begin
      wr_enable_d <= wr_enable;
      if (wr_rise) begin
        wr_store <= wave_sel;
      end
      if (wr_fire) begin
        wr_ptr <= wr_ptr_eff + PTR_STEP;
      end else if (wr_rise) begin
        wr_ptr <= '0;
      end
      first_cyc <= 1'b0;
      sel_r     <= wave_sel;
      rd_store  <= sel_r;
      acc       <= acc_clr ? '0 : acc_nxt;
      addr_r    <= addr_nxt;
      wave_out  <= wr_enable ? '0 : rd_sample;
    end
  end

  // RAM has no reset: contents survive rstn so a partial reload keeps the old tail.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < LANES; i++) begin
        tbl[i][wr_row] <= wr_data[VR*i +: VR];
      end
    end
  end

endmodule

// File: doc/dds_wave_core.md
# dds_wave_core

Per-channel DDS engine that sits directly downstream of the DDS register slave: one instance per output channel. It stores up to 2**WAVE_STORE single-period waveforms loaded through the slave's data port. It runs a phase accumulator using the frequency and phase words of the selected store, and emits one VERTICAL_RESOLUTION-bit sample per clock on `wave_out`.

## Interface
- HORIZON_RESOLUTION, 12: log2 of samples per waveform period (table depth 4096).
- ADDER_LOWBIT, 20: fractional accumulator bits; accumulator width AW = HORIZON_RESOLUTION+ADDER_LOWBIT = 32.
- WAVE_STORE, 2: log2 of waveform stores (4 stores).
- VERTICAL_RESOLUTION, 8: sample width; fixed at 8 (4 samples per 32-bit write word).
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- wave_sel  in  WAVE_STORE  selects the active store for playback and for loading.
- freq_ctrl  in  (2**WAVE_STORE)*AW  packed; element k = frequency word of store k.
- phase_ctrl  in  (2**WAVE_STORE)*HORIZON_RESOLUTION  packed; element k = phase offset of store k.
- wave_out  out  VERTICAL_RESOLUTION  output sample, registered.
- wr_enable  in  1  load mode; level signal from slave.
- wr_valid  in  1  one-cycle strobe: wr_data is a table word.
- wr_data  in  32  four samples, byte 0 first.

## Operation
- Table RAM: 2**WAVE_STORE × 2**HORIZON_RESOLUTION × 8 simple dual-port, synchronous read. Initialised to all zeros at configuration; not cleared by reset.
- Load path:
  - On rising edge of wr_enable (registered copy `wr_enable_d` = 0, input = 1): latch `wr_store` ← wave_sel and set `wr_ptr` ← 0.
  - Each cycle with wr_enable=1 and wr_valid=1: write wr_data[8i+7:8i] to sample wr_ptr+i of wr_store, for i=0..3. Then wr_ptr ← wr_ptr+4 mod 4096.
  - The 1025th word therefore overwrites samples 0..3.
  - wr_valid with wr_enable=0 is ignored.
  - Changes to wave_sel during a load do not move wr_store.
- Playback:
  - `sel_r` registers wave_sel every cycle.
  - Accumulator `acc` (AW bits) is set to 0 when any of these hold: wr_enable=1, `sel_r` ≠ wave_sel, or the cycle after reset.
  - Otherwise acc ← acc + freq_ctrl[sel_r], modulo 2**AW (no saturation).
  - Address `addr_r` ← (acc[AW-1:ADDER_LOWBIT] + phase_ctrl[sel_r]) mod 4096, registered with `sel_r` as the store index.
  - wave_out ← RAM[store][addr_r] (RAM output register).
  - While wr_enable=1, wave_out is forced to 0.
- freq_ctrl = 0: acc holds; wave_out is constant at sample phase_ctrl of the selected store.
- Read-during-write to the same RAM location returns old data. This is not observable during a load, because the output is forced to 0.

## Timing
- Reset values: wave_out=0, acc=0, addr_r=0, sel_r=0, wr_ptr=0, wr_store=0, wr_enable_d=0.
- Pipeline: acc value at cycle t → addr_r at t+1 → wave_out at t+2.
- wave_out(t+2) = table[sel_r(t)][(acc(t)[31:20] + phase_ctrl[sel_r(t)](t)) mod 4096].
- A freq_ctrl change at cycle t affects acc at t+1 and wave_out at t+3.
- A phase_ctrl change at cycle t affects wave_out at t+2.
- wave_sel change at cycle t:
  - sel_r updates at t+1.
  - acc is 0 at t+1.
  - The first new-store sample (index phase_ctrl) appears at t+3.
- wr_enable rise at t: wave_out is 0 from t+1 onward. The first wr_valid may arrive at t+1.
- wr_enable fall at t: acc is 0 at t+1, and the first playback sample appears at t+3.
- A write at cycle t is readable by playback from t+1.
- Reset asserted mid-load or mid-playback: all registers return to reset values immediately.
  - RAM contents written before reset are retained.
  - A partially loaded table keeps its old tail.

## Test plan
- Ramp load and playback: store 0 with wave_sel=0, wr_enable=1, 1024 words 0x03020100, 0x07060504, … (wrapping modulo 256); drop wr_enable; freq_ctrl[0]=0x0010_0000, phase_ctrl[0]=0 -> wave_out = 0,1,2,…,255,0,… from 3 cycles after the fall.
- Phase and fractional step: same table, freq_ctrl[0]=0x0008_0000, phase_ctrl[0]=0x010 -> wave_out = 16,16,17,17,18,…; accumulator wraps after 8192 cycles without a glitch.
- Store switch: load store 1 with constant 0xA5A5A5A5; play store 0; set wave_sel=1 at cycle t -> wave_out = 0xA5 from t+3, with store-0 samples until then.
- Pointer wrap: load 1025 words into store 2, the last being 0xDDCCBBAA; freq_ctrl[2]=0x0010_0000 -> first four samples read 0xAA,0xBB,0xCC,0xDD.
- Load mid-playback: raise wr_enable while playing -> wave_out=0 next cycle; wr_valid with wr_enable=0 leaves the table unchanged.
- Reset mid-load: assert rstn=0 after 10 words -> wave_out=0, wr_ptr=0; a new load restarts at sample 0 and the previously written samples 40..4095 are intact.
